// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES widths, arbiter FSM state encoding and small helpers
//            used by the AES core arbiter and its round-robin picker.
// Revision : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int AES_BLOCK_W         = 128;
    localparam int AES_KEY_W_DEFAULT   = 128;
    localparam int AES_TIMEOUT_DEFAULT = 64;

    // Arbiter FSM encoding, two bits, one register per bit
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    // Requester index to one-hot requester mask
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : aes_rr_pick
// Purpose  : Two-way round-robin pick. With both requesters valid, the one
//            that was not served last wins; otherwise the lone valid wins.
// Revision : 1.0  initial release
// ============================================================================
module aes_rr_pick (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant from the valid mask and the last-served requester
    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aes_core_arbiter
// Purpose  : Shares one iterative AES encrypt core between two requesters.
//            Round-robin accept in IDLE, one-cycle core launch, bounded wait
//            for core_done, then a held response to the owning requester.
// Revision : 1.0  initial release
// ============================================================================
module aes_core_arbiter
    import aes_pkg::*;
#(
    parameter int N       = AES_KEY_W_DEFAULT,
    parameter int Nr      = 10,
    parameter int Nk      = 4,
    parameter int TIMEOUT = AES_TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [AES_BLOCK_W-1:0] req_in0,
    input  logic [AES_BLOCK_W-1:0] req_in1,
    input  logic [N-1:0]           req_key0,
    input  logic [N-1:0]           req_key1,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [AES_BLOCK_W-1:0] rsp_data,
    output logic                   core_start,
    output logic [AES_BLOCK_W-1:0] core_in,
    output logic [N-1:0]           core_key,
    input  logic [AES_BLOCK_W-1:0] core_out,
    input  logic                   core_done,
    output logic                   busy,
    output logic                   err
);

    localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    // Named scope that only appears in the elaborated hierarchy when the key
    // width, key-word count and round count do not describe one AES variant.
    if (N != 32 * Nk || Nr != Nk + 6) begin : g_cfg_mismatch
    end

    arb_state_t    state;
    logic          last_grant;
    logic          owner;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    grant;
    logic          timeout_hit;

    aes_rr_pick u_pick (
        .valid (req_valid),
        .last  (last_grant),
        .grant (grant)
    );

    assign timeout_hit = (wait_cnt == CNT_MAX);

    // Arbiter FSM: accept, launch, wait for the core, hold the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            wait_cnt   <= '0;
            core_in    <= '0;
            core_key   <= '0;
            rsp_data   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        core_in  <= grant[1] ? req_in1  : req_in0;
                        core_key <= grant[1] ? req_key1 : req_key0;
                        owner    <= grant[1];
                        state    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // core_done takes priority over an expiring wait
                    if (core_done) begin
                        rsp_data <= core_out;
                        state    <= ST_RESP;
                    end else if (timeout_hit) begin
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[owner]) begin
                        last_grant <= owner;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output decode from the state registers, forced low while in reset
    always_comb begin
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        core_start = 1'b0;
        busy       = 1'b0;
        err        = 1'b0;
        if (!rst) begin
            busy = (state != ST_IDLE);
            case (state)
                ST_IDLE:   req_ready  = grant;
                ST_LAUNCH: core_start = 1'b1;
                ST_WAIT:   err        = timeout_hit && !core_done;
                ST_RESP:   rsp_valid  = onehot2(owner);
                default:   ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_core_arbiter
// Purpose  : Directed self-checking bench for aes_core_arbiter with a small
//            behavioural encrypt-core model (fixed 3-cycle latency).
// Revision : 1.0  initial release
// ============================================================================
module tb_aes_core_arbiter;

    localparam int N       = 128;
    localparam int TIMEOUT = 64;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_in0, req_in1;
    logic [N-1:0] req_key0, req_key1;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [127:0] rsp_data;
    logic         core_start;
    logic [127:0] core_in;
    logic [N-1:0] core_key;
    logic [127:0] core_out;
    logic         core_done;
    logic         busy;
    logic         err;

    // Core model state and spurious-done injector
    logic         model_en   = 1'b1;
    int           cd         = 0;
    logic         model_done = 1'b0;
    logic [127:0] model_out  = '0;
    logic         spur_done;
    logic [127:0] spur_out;

    int n_tests = 0;
    int n_fail  = 0;

    assign core_done = model_done | spur_done;
    assign core_out  = spur_done ? spur_out : model_out;

    always #5 clk = ~clk;

    aes_core_arbiter #(.N(N), .Nr(10), .Nk(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in0(req_in0), .req_in1(req_in1),
        .req_key0(req_key0), .req_key1(req_key1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .core_start(core_start), .core_in(core_in), .core_key(core_key),
        .core_out(core_out), .core_done(core_done),
        .busy(busy), .err(err)
    );

    // Reference encrypt: the FIPS-197 vector, else a simple in^key stand-in
    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] k);
        if (pt == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return pt ^ k;
    endfunction

    // Core model: done pulse three cycles after core_start is seen
    always @(posedge clk) begin
        model_done <= 1'b0;
        if (core_start && model_en) begin
            cd <= 3;
        end else if (cd != 0) begin
            cd <= cd - 1;
            if (cd == 1) begin
                model_done <= 1'b1;
                model_out  <= ref_enc(core_in, core_key);
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a grant, check it, then cross the accept edge
    task automatic wait_grant(input logic [1:0] exp, output int waited);
        waited = 0;
        #1;
        while (req_ready == 2'b00 && waited < 20) begin
            step();
            waited++;
        end
        chk("grant", req_ready, exp);
        step();
    endtask

    task automatic wait_rsp(input logic [1:0] exp_v, input logic [127:0] exp_d);
        int k = 0;
        while (rsp_valid == 2'b00 && k < TIMEOUT + 20) begin
            step();
            k++;
        end
        chk("rsp_valid", rsp_valid, exp_v);
        chk("rsp_data", rsp_data, exp_d);
    endtask

    task automatic handshake(input logic [1:0] port);
        rsp_ready = port;
        step();
        rsp_ready = 2'b00;
        chk("idle_after_hs", busy, 1'b0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, k, errs, err_at, seen_rsp, seen_busy, seen_done;
        logic [127:0] hold;

        rst = 1'b1; req_valid = 2'b01; rsp_ready = 2'b00;
        req_in0 = '0; req_in1 = '0; req_key0 = '0; req_key1 = '0;
        spur_done = 1'b0; spur_out = '0;

        // Reset: outputs low even with a pending request
        step(); step();
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rsp_data", rsp_data, 128'h0);
        chk("rst_core_in", core_in, 128'h0);
        req_valid = 2'b00;
        rst = 1'b0;
        step();

        // Scenario 1: FIPS-197 vector through port 0
        req_in0 = FIPS_PT; req_key0 = FIPS_KEY; req_valid = 2'b01;
        wait_grant(2'b01, w);
        req_valid = 2'b00;
        chk("s1_core_start", core_start, 1'b1);
        chk("s1_core_in", core_in, FIPS_PT);
        chk("s1_core_key", core_key, FIPS_KEY);
        step();
        chk("s1_start_one_cycle", core_start, 1'b0);
        k = 0;
        while (!model_done && k < 20) begin step(); k++; end
        chk("s1_no_rsp_at_done", rsp_valid, 2'b00);
        step();
        chk("s1_rsp_valid_lat1", rsp_valid, 2'b01);
        chk("s1_rsp_data", rsp_data, FIPS_CT);
        handshake(2'b01);

        // Scenario 2: both valid from reset, strict alternation
        reset_dut();
        req_in0 = 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978;
        req_key0 = 128'hffff_0000_ffff_0000_1111_2222_3333_4444;
        req_in1 = 128'hcafe_babe_dead_beef_0bad_f00d_1234_5678;
        req_key1 = 128'h5555_aaaa_5555_aaaa_9999_8888_7777_6666;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ev;
            ev = (i % 2 == 0) ? 2'b01 : 2'b10;
            wait_grant(ev, w);
            if (i > 0) chk("s2_turnaround", w, 0);
            wait_rsp(ev, (ev == 2'b01) ? (req_in0 ^ req_key0) : (req_in1 ^ req_key1));
            handshake(ev);
        end
        req_valid = 2'b00;

        // Scenario 3: response stalled five cycles, non-owner ready ignored
        req_in0 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        req_key0 = 128'h0f0f_0f0f_0f0f_0f0f_f0f0_f0f0_f0f0_f0f0;
        req_valid = 2'b01;
        wait_grant(2'b01, w);
        req_valid = 2'b00;
        hold = req_in0 ^ req_key0;
        wait_rsp(2'b01, hold);
        req_valid = 2'b10;
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s3_rsp_valid", rsp_valid, 2'b01);
            chk("s3_rsp_data", rsp_data, hold);
            chk("s3_req_ready", req_ready, 2'b00);
            chk("s3_busy", busy, 1'b1);
        end
        req_valid = 2'b00;
        handshake(2'b01);

        // Scenario 4: core never answers, single err pulse at TIMEOUT
        model_en = 1'b0;
        req_in1 = 128'h7; req_key1 = 128'h9;
        req_valid = 2'b10;
        wait_grant(2'b10, w);
        req_valid = 2'b00;
        chk("s4_core_start", core_start, 1'b1);
        errs = 0; err_at = -1; seen_rsp = 0;
        for (int j = 1; j <= TIMEOUT + 4; j++) begin
            step();
            if (err) begin
                errs++;
                if (err_at < 0) err_at = j;
            end
            if (rsp_valid != 2'b00) seen_rsp = 1;
        end
        chk("s4_err_count", errs, 1);
        chk("s4_err_at", err_at, TIMEOUT);
        chk("s4_no_rsp", seen_rsp, 0);
        chk("s4_idle", busy, 1'b0);
        model_en = 1'b1;

        // Scenario 5: reset during WAIT, later core_done ignored
        req_in0 = 128'habc; req_key0 = 128'h123;
        req_valid = 2'b01;
        wait_grant(2'b01, w);
        req_valid = 2'b00;
        step();
        step();
        chk("s5_in_wait", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("s5_rst_busy", busy, 1'b0);
        chk("s5_rst_err", err, 1'b0);
        step();
        rst = 1'b0;
        chk("s5_post_busy", busy, 1'b0);
        chk("s5_post_rsp_valid", rsp_valid, 2'b00);
        chk("s5_post_err", err, 1'b0);
        chk("s5_post_core_start", core_start, 1'b0);
        seen_busy = 0; seen_rsp = 0; seen_done = 0; errs = 0;
        for (int j = 0; j < 6; j++) begin
            step();
            if (busy) seen_busy = 1;
            if (rsp_valid != 2'b00) seen_rsp = 1;
            if (err) errs++;
            if (model_done) seen_done = 1;
        end
        chk("s5_late_done_seen", seen_done, 1);
        chk("s5_stay_idle", seen_busy, 0);
        chk("s5_no_rsp", seen_rsp, 0);
        chk("s5_no_err", errs, 0);
        chk("s5_rsp_data", rsp_data, 128'h0);

        // Scenario 6: spurious core_done in IDLE and RESP
        spur_out = 128'hdead_dead_dead_dead_dead_dead_dead_dead;
        spur_done = 1'b1;
        step();
        spur_done = 1'b0;
        chk("s6_idle_busy", busy, 1'b0);
        chk("s6_idle_data", rsp_data, 128'h0);
        chk("s6_idle_rsp_valid", rsp_valid, 2'b00);
        req_in0 = 128'h4444; req_key0 = 128'h0101;
        req_valid = 2'b01;
        wait_grant(2'b01, w);
        req_valid = 2'b00;
        hold = req_in0 ^ req_key0;
        wait_rsp(2'b01, hold);
        spur_out = 128'hbeef_beef_beef_beef_beef_beef_beef_beef;
        spur_done = 1'b1;
        step();
        spur_done = 1'b0;
        chk("s6_resp_valid", rsp_valid, 2'b01);
        chk("s6_resp_data", rsp_data, hold);
        chk("s6_resp_busy", busy, 1'b1);
        handshake(2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_core_arbiter.md
AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 128, meaning key width in bits (128/192/256).
REQ-002 The block SHALL have parameter Nr, default 10, meaning round count, passed through for documentation and consistency checks only.
REQ-003 The block SHALL have parameter Nk, default 4, meaning key words, passed through for documentation and consistency checks only.
REQ-004 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles to wait for core_done.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port req_valid, input, 2 bits: per-requester request valid.
REQ-008 The block SHALL have port req_ready, output, 2 bits: per-requester accept, at most one bit high.
REQ-009 The block SHALL have ports req_in0 and req_in1, input, 128 bits each: plaintext for requesters 0 and 1.
REQ-010 The block SHALL have ports req_key0 and req_key1, input, N bits each: keys for requesters 0 and 1.
REQ-011 The block SHALL have port rsp_valid, output, 2 bits: one-hot response valid, routed to the owning requester.
REQ-012 The block SHALL have port rsp_ready, input, 2 bits: per-requester response accept.
REQ-013 The block SHALL have port rsp_data, output, 128 bits: ciphertext, shared between both requesters.
REQ-014 The block SHALL have port core_start, output, 1 bit: one-cycle start pulse to the iterative encrypt core.
REQ-015 The block SHALL have ports core_in (output, 128 bits) and core_key (output, N bits): registered operands to the core.
REQ-016 The block SHALL have ports core_out (input, 128 bits) and core_done (input, 1 bit): core result and its one-cycle done pulse.
REQ-017 The block SHALL have port busy, output, 1 bit: high whenever the FSM state is not IDLE.
REQ-018 The block SHALL have port err, output, 1 bit: one-cycle timeout pulse.

Function
REQ-019 The FSM SHALL have four states, IDLE, LAUNCH, WAIT and RESP, all held in registers.
REQ-020 In IDLE with any req_valid set, the block SHALL grant the requester chosen by round-robin, asserting req_ready for that requester only, combinationally in that same cycle.
REQ-021 The round-robin grant SHALL prefer the requester other than last_grant when both req_valid bits are high, and otherwise grant the single valid requester.
REQ-022 On the accept cycle T, the block SHALL register the granted in/key into core_in/core_key, set owner to the granted requester, and enter LAUNCH.
REQ-023 In LAUNCH (cycle T+1), the block SHALL drive core_start=1 for exactly one cycle, clear the wait counter, and enter WAIT.
REQ-024 core_in and core_key SHALL remain stable from cycle T+1 until the block leaves WAIT.
REQ-025 In WAIT, core_done=1 SHALL cause the block to register core_out into rsp_data and enter RESP.
REQ-026 In WAIT, if the wait counter reaches TIMEOUT-1 without core_done, the block SHALL pulse err for one cycle, enter IDLE, and issue no response.
REQ-027 If core_done and the timeout occur in the same cycle, core_done SHALL win.
REQ-028 In RESP, the block SHALL drive rsp_valid[owner]=1 with rsp_data held stable until rsp_ready[owner]=1.
REQ-029 On the rsp_ready[owner] handshake, the block SHALL update last_grant to owner and enter IDLE.
REQ-030 rsp_ready of the non-owner requester SHALL be ignored.
REQ-031 req_ready SHALL be 0 in every state except IDLE, so only one operation is ever in flight.
REQ-032 core_done SHALL be ignored in IDLE, LAUNCH and RESP.
REQ-033 The latency from core_done to rsp_valid SHALL be 1 cycle, and the minimum turnaround from the response handshake to the next accept SHALL be 1 cycle (the IDLE cycle).
REQ-034 The wait counter SHALL be sized clog2(TIMEOUT) bits, SHALL saturate, and SHALL NOT wrap.

Reset
REQ-035 With rst=1 at a clock edge, the block SHALL set state=IDLE, last_grant=1 (so requester 0 wins first), owner=0, counter=0, and core_in, core_key and rsp_data to 0.
REQ-036 While rst is asserted, all outputs (req_ready, rsp_valid, core_start, busy, err) SHALL be 0.
REQ-037 A reset asserted mid-operation SHALL abandon the operation with no response and no err pulse; the core SHALL share the same rst.

Structure
REQ-038 The state encoding, TIMEOUT default and the AES width constants SHALL live in the shared package aes_pkg.
REQ-039 The two-way round-robin pick SHALL be implemented as sub-module aes_rr_pick (inputs: valid[1:0] and last; output: one-hot grant).
REQ-040 The encrypt core SHALL be instantiated outside this block, alongside it.

Verification
REQ-041 Scenario 1: with the real core, port 0 sends in=00112233445566778899aabbccddeeff and key=000102030405060708090a0b0c0d0e0f; the bench SHALL check rsp_valid=01 and rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-042 Scenario 2: both req_valid bits high right after reset; the bench SHALL check grants in the order port 0 then port 1, and strict alternation over 4 requests.
REQ-043 Scenario 3: rsp_ready held 0 for 5 cycles in RESP; the bench SHALL check that rsp_valid and rsp_data stay stable, req_ready=00 and busy=1 throughout.
REQ-044 Scenario 4: a core model that never asserts done; the bench SHALL check that err pulses exactly once, TIMEOUT cycles after core_start, followed by IDLE and no rsp_valid.
REQ-045 Scenario 5: rst pulsed during WAIT; the bench SHALL check that all outputs are 0 the next cycle and that a later core_done is ignored.
REQ-046 Scenario 6: spurious core_done pulses in IDLE and RESP; the bench SHALL check that state and rsp_data are unchanged.
